// File: rtl/nt35510_pkg.sv
// Shared definitions for the NT35510 fill arbiter: adapter register offsets,
// DCS command codes and the arbiter state encoding.
package nt35510_pkg;

    localparam logic [31:0] INSTR_OFS = 32'd0;
    localparam logic [31:0] DATA_OFS  = 32'd4;

    localparam logic [15:0] CASET = 16'h2A00;
    localparam logic [15:0] RASET = 16'h2B00;
    localparam logic [15:0] RAMWR = 16'h2C00;

    // Step 0..15 program the window, 16 issues RAMWR, 17 streams pixels.
    localparam logic [4:0] RAMWR_STEP = 5'd16;
    localparam logic [4:0] PIX_STEP   = 5'd17;

    typedef enum logic [2:0] {
        IDLE,
        CPU,
        F_SETUP,
        F_ACCESS,
        F_DONE
    } arb_state_t;

    // Window parameter bytes in transmission order: x0, x1, y0, y1, high byte first.
    function automatic logic [7:0] window_byte(input logic [2:0] idx,
                                               input logic [15:0] x0, x1, y0, y1);
        logic [7:0] b;
        case (idx)
            3'd0:    b = x0[15:8];
            3'd1:    b = x0[7:0];
            3'd2:    b = x1[15:8];
            3'd3:    b = x1[7:0];
            3'd4:    b = y0[15:8];
            3'd5:    b = y0[7:0];
            3'd6:    b = y1[15:8];
            default: b = y1[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nt35510_fill_seq.sv
// Fill-engine sequencer: walks the CASET/RASET/RAMWR preamble and then counts
// pixels, presenting the address/data of the current engine write.
module nt35510_fill_seq
    import nt35510_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] y0,
    input  logic [15:0] y1,
    input  logic [15:0] color,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        last
);

    logic [15:0]      x0_q, x1_q, y0_q, y1_q, color_q;
    logic [4:0]       step;
    logic [CNT_W-1:0] pix_rem;
    logic [CNT_W-1:0] width, height, area;

    // Pixel count is formed from the live operands so it is ready on the load edge.
    assign width  = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
    assign height = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);
    assign area   = width * height;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            step    <= '0;
            pix_rem <= '0;
        end else if (load) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            color_q <= color;
            step    <= '0;
            pix_rem <= area;
        end else if (advance) begin
            if (step != PIX_STEP)
                step <= step + 5'd1;
            else if (pix_rem != '0)
                pix_rem <= pix_rem - CNT_W'(1);
        end
    end

    always_comb begin
        addr  = BASE_ADDR + INSTR_OFS;
        wdata = '0;
        if (!step[4]) begin
            if (step[0]) begin
                addr  = BASE_ADDR + DATA_OFS;
                wdata = {24'd0, window_byte(step[3:1], x0_q, x1_q, y0_q, y1_q)};
            end else begin
                wdata = {16'd0, (step[3] ? RASET : CASET) | {14'd0, step[2:1]}};
            end
        end else if (step == RAMWR_STEP) begin
            wdata = {16'd0, RAMWR};
        end else begin
            addr  = BASE_ADDR + DATA_OFS;
            wdata = {16'd0, color_q};
        end
    end

    // A pixel count truncated to zero ends the sequence at RAMWR.
    assign last = ((step == RAMWR_STEP) && (pix_rem == '0)) ||
                  ((step == PIX_STEP) && (pix_rem == CNT_W'(1)));

endmodule

// File: rtl/nt35510_fill_arbiter.sv
// Owns the NT35510 adapter APB port, sharing it between CPU pass-through and an
// atomic rectangle-fill engine.
module nt35510_fill_arbiter
    import nt35510_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_paddr,
    input  logic        S_psel,
    input  logic        S_penable,
    input  logic        S_pwrite,
    input  logic [31:0] S_pwdata,
    output logic        S_pready,
    output logic [31:0] S_prdata,
    output logic        S_pslverr,
    output logic [31:0] M_paddr,
    output logic        M_psel,
    output logic        M_penable,
    output logic        M_pwrite,
    output logic [31:0] M_pwdata,
    input  logic        M_pready,
    input  logic [31:0] M_prdata,
    input  logic        fill_start,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] y0,
    input  logic [15:0] y1,
    input  logic [15:0] color,
    input  logic        fill_abort,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fill_err
);

    arb_state_t  state, state_next;
    logic        pending, gap, fin, reject;
    logic        done_err, enter_done, start_ok, bad_window, xfer_end, engine_sel;
    logic [31:0] seq_addr, seq_wdata;
    logic        seq_last;

    assign S_pslverr  = 1'b0;
    assign bad_window = (x1 < x0) || (y1 < y0);
    assign start_ok   = fill_start && !fill_busy;
    assign xfer_end   = (state == F_ACCESS) && M_pready;
    assign enter_done = (state_next == F_DONE) && (state != F_DONE);

    nt35510_fill_seq #(
        .BASE_ADDR (BASE_ADDR),
        .CNT_W     (CNT_W)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok && !bad_window),
        .advance (xfer_end),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .color   (color),
        .addr    (seq_addr),
        .wdata   (seq_wdata),
        .last    (seq_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (S_psel) begin
                    state_next = CPU;
                end else if (pending) begin
                    state_next = fill_abort ? F_DONE : F_SETUP;
                    done_err   = fill_abort;
                end
            end
            CPU: begin
                if (S_psel && S_penable && M_pready) state_next = IDLE;
            end
            F_SETUP: begin
                // gap marks the mandatory idle cycle: the only point where the
                // engine may finish or honour an abort.
                if (!gap) begin
                    state_next = F_ACCESS;
                end else if (fin) begin
                    state_next = F_DONE;
                end else if (fill_abort) begin
                    state_next = F_DONE;
                    done_err   = 1'b1;
                end
            end
            F_ACCESS: begin
                if (M_pready) state_next = F_SETUP;
            end
            F_DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        engine_sel = ((state == F_SETUP) && !gap) || (state == F_ACCESS);
        M_paddr    = S_paddr;
        M_psel     = S_psel;
        M_penable  = S_penable;
        M_pwrite   = S_pwrite;
        M_pwdata   = S_pwdata;
        S_pready   = M_pready;
        S_prdata   = M_prdata;
        if (state inside {F_SETUP, F_ACCESS, F_DONE}) begin
            M_paddr   = seq_addr;
            M_psel    = engine_sel;
            M_penable = (state == F_ACCESS);
            M_pwrite  = engine_sel;
            M_pwdata  = seq_wdata;
            S_pready  = 1'b0;
            S_prdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            gap       <= 1'b0;
            fin       <= 1'b0;
            reject    <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            gap       <= xfer_end;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            if (xfer_end) fin <= seq_last;
            if ((state == IDLE) && !S_psel && pending) pending <= 1'b0;
            // An empty window never reaches the bus; it completes one cycle after capture.
            if (reject) begin
                reject    <= 1'b0;
                fill_done <= 1'b1;
                fill_err  <= 1'b1;
                fill_busy <= 1'b0;
            end
            if (enter_done) begin
                fill_done <= 1'b1;
                fill_err  <= done_err;
                fill_busy <= 1'b0;
            end
            if (start_ok) begin
                fill_busy <= 1'b1;
                fin       <= 1'b0;
                if (bad_window) reject  <= 1'b1;
                else            pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nt35510_fill_arbiter.sv
// Self-checking bench for nt35510_fill_arbiter: a latency-programmable APB
// adapter model, a scoreboard of expected adapter writes, and directed sequences.
module tb_nt35510_fill_arbiter;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          MAXC = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] S_paddr = '0;
    logic        S_psel = 1'b0, S_penable = 1'b0, S_pwrite = 1'b0;
    logic [31:0] S_pwdata = '0;
    logic        S_pready, S_pslverr;
    logic [31:0] S_prdata;
    logic [31:0] M_paddr, M_pwdata, M_prdata;
    logic        M_psel, M_penable, M_pwrite, M_pready;
    logic        fill_start = 1'b0, fill_abort = 1'b0;
    logic [15:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0, color = '0;
    logic        fill_busy, fill_done, fill_err;

    nt35510_fill_arbiter #(.BASE_ADDR(BASE), .CNT_W(20)) dut (
        .clk(clk), .rst(rst),
        .S_paddr(S_paddr), .S_psel(S_psel), .S_penable(S_penable), .S_pwrite(S_pwrite),
        .S_pwdata(S_pwdata), .S_pready(S_pready), .S_prdata(S_prdata), .S_pslverr(S_pslverr),
        .M_paddr(M_paddr), .M_psel(M_psel), .M_penable(M_penable), .M_pwrite(M_pwrite),
        .M_pwdata(M_pwdata), .M_pready(M_pready), .M_prdata(M_prdata),
        .fill_start(fill_start), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .fill_abort(fill_abort), .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Adapter model: ready after 'lat' wait cycles in the access phase.
    int unsigned lat = 1;
    int unsigned wcnt = 0;
    assign M_pready = M_psel && M_penable && (wcnt >= lat);
    assign M_prdata = {16'hBEEF, M_paddr[15:0]};
    always @(posedge clk) begin
        if (!(M_psel && M_penable) || M_pready) wcnt <= 0;
        else                                    wcnt <= wcnt + 1;
    end

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int  xfer_cnt = 0;
    int  psel_cnt = 0;
    bit  gap_chk  = 0;

    // Monitor: every completed adapter transfer is popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gap_chk = 0;
        end else begin
            if (M_psel) psel_cnt++;
            if (gap_chk) check(M_psel == 1'b0, "idle_gap", {31'd0, M_psel}, 32'd0);
            gap_chk = 0;
            if (M_psel && M_penable && M_pready) begin
                xfer_cnt++;
                gap_chk = 1;
                if (exp_q.size() == 0) begin
                    check(1'b0 == M_psel, "unexpected_xfer", M_paddr, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(M_paddr == e.addr, "xfer_addr", M_paddr, e.addr);
                    check(M_pwdata == e.data, "xfer_data", M_pwdata, e.data);
                    check(M_pwrite == e.write, "xfer_write", {31'd0, M_pwrite}, {31'd0, e.write});
                end
            end
        end
    end

    function automatic void push_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.write = w;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endfunction

    // Reference fill traffic: window pairs, RAMWR, then up to max_pix colour writes.
    function automatic void push_fill(input logic [15:0] a, b, c, d, col, input int max_pix);
        logic [15:0] v [4];
        int n;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                push_xfer(1'b1, BASE, ((i < 2) ? 32'h2A00 : 32'h2B00) + 32'((i % 2) * 2 + k));
                push_xfer(1'b1, BASE + 32'd4, (k == 0) ? {24'd0, v[i][15:8]} : {24'd0, v[i][7:0]});
            end
        end
        push_xfer(1'b1, BASE, 32'h2C00);
        n = (int'(b) - int'(a) + 1) * (int'(d) - int'(c) + 1);
        if (max_pix >= 0 && max_pix < n) n = max_pix;
        for (int p = 0; p < n; p++) push_xfer(1'b1, BASE + 32'd4, {16'd0, col});
    endfunction

    task automatic start_fill(input logic [15:0] a, b, c, d, col);
        @(posedge clk); #1;
        x0 = a; x1 = b; y0 = c; y1 = d; color = col;
        fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output logic err, output bit seen);
        seen = 0;
        err  = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (fill_done) begin
                seen = 1;
                err  = fill_err;
            end
        end
    endtask

    task automatic cpu_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input bit chk_mirror, output logic [31:0] rd, output int cyc);
        bit got;
        @(posedge clk); #1;
        S_paddr = a; S_pwrite = w; S_pwdata = d; S_psel = 1'b1; S_penable = 1'b0;
        if (chk_mirror) begin
            @(negedge clk);
            check(M_psel && !M_penable && (M_pwrite == w), "mirror_ctrl",
                  {29'd0, M_psel, M_penable, M_pwrite}, {29'd0, 2'b10, w});
            check(M_paddr == a, "mirror_addr", M_paddr, a);
            check(M_pwdata == d, "mirror_wdata", M_pwdata, d);
        end
        @(posedge clk); #1;
        S_penable = 1'b1;
        cyc = 0;
        got = 0;
        rd  = '0;
        while (!got && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (S_pready) begin
                got = 1;
                rd  = S_prdata;
            end
        end
        check(got, "cpu_ready", 32'(cyc), 32'(MAXC));
        @(posedge clk); #1;
        S_psel = 1'b0; S_penable = 1'b0; S_pwrite = 1'b0; S_pwdata = '0; S_paddr = '0;
    endtask

    typedef struct {
        logic [15:0] x0, x1, y0, y1, color;
        logic        exp_err;
        int          exp_n;
    } fill_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t   vecs [4];
        logic [31:0] rd;
        int          cyc, base, pbase, dcnt;
        logic        err;
        bit          seen, hit;
        time         t_done, t_rd;

        vecs[0] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'hF800, 1'b0, 21};
        vecs[1] = '{16'd3, 16'd3, 16'd7, 16'd7, 16'h001F, 1'b0, 18};
        vecs[2] = '{16'd2, 16'd4, 16'h0100, 16'h0101, 16'h07E0, 1'b0, 23};
        vecs[3] = '{16'd0, 16'd5, 16'd9, 16'd2, 16'h1234, 1'b1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({M_psel, M_penable, M_pwrite, fill_busy, fill_done, fill_err, S_pslverr} == 7'd0,
              "reset_ctrl", {25'd0, M_psel, M_penable, M_pwrite, fill_busy, fill_done, fill_err, S_pslverr}, 32'd0);
        check(M_paddr == 32'd0, "reset_paddr", M_paddr, 32'd0);
        check(M_pwdata == 32'd0, "reset_pwdata", M_pwdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // CPU pass-through write with a six-cycle access phase
        lat = 5;
        push_xfer(1'b1, BASE, 32'h0000_1100);
        cpu_xfer(BASE, 1'b1, 32'h0000_1100, 1'b1, rd, cyc);
        check(cyc == 6, "cpu_wait_cycles", 32'(cyc), 32'd6);
        lat = 1;

        // Table of fills
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            base = xfer_cnt;
            if (!vecs[i].exp_err) push_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color, -1);
            start_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color);
            wait_done(MAXC, err, seen);
            check(seen, "tbl_done_seen", 32'(i), 32'd1);
            check(err == vecs[i].exp_err, "tbl_done_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
            @(posedge clk);
            check(xfer_cnt - base == vecs[i].exp_n, "tbl_xfer_count", 32'(xfer_cnt - base), 32'(vecs[i].exp_n));
            check(exp_q.size() == 0, "tbl_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Rejected window: busy for one cycle, done+err two cycles after the request
        pbase = psel_cnt;
        start_fill(16'd9, 16'd5, 16'd0, 16'd0, 16'hFFFF);
        @(negedge clk);
        check(fill_busy && !fill_done, "reject_cycle1", {30'd0, fill_busy, fill_done}, 32'd2);
        @(negedge clk);
        check(fill_done && fill_err && !fill_busy, "reject_cycle2",
              {29'd0, fill_done, fill_err, fill_busy}, 32'd6);
        repeat (3) @(negedge clk);
        check(psel_cnt == pbase, "reject_no_traffic", 32'(psel_cnt - pbase), 32'd0);

        // CPU read issued mid-fill stalls until the fill completes
        push_fill(16'd0, 16'd1, 16'd0, 16'd1, 16'hF800, -1);
        push_xfer(1'b0, BASE + 32'd4, 32'd0);
        fork
            begin
                start_fill(16'd0, 16'd1, 16'd0, 16'd1, 16'hF800);
                wait_done(MAXC, err, seen);
                t_done = $time;
            end
            begin
                repeat (8) @(posedge clk);
                cpu_xfer(BASE + 32'd4, 1'b0, 32'd0, 1'b0, rd, cyc);
                t_rd = $time;
            end
        join
        check(seen && !err, "midread_fill_ok", {30'd0, seen, err}, 32'd2);
        check(rd == 32'hBEEF_1004, "midread_rdata", rd, 32'hBEEF_1004);
        check(t_rd > t_done, "midread_after_done", 32'(t_rd), 32'(t_done));
        check(exp_q.size() == 0, "midread_queue_empty", 32'(exp_q.size()), 32'd0);

        // fill_start together with a CPU setup: CPU first, repeat request ignored
        push_xfer(1'b1, BASE, 32'h0000_0036);
        push_fill(16'd1, 16'd2, 16'd0, 16'd0, 16'h07E0, -1);
        fork
            cpu_xfer(BASE, 1'b1, 32'h0000_0036, 1'b0, rd, cyc);
            begin
                start_fill(16'd1, 16'd2, 16'd0, 16'd0, 16'h07E0);
                repeat (6) @(posedge clk);
                start_fill(16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF);
                wait_done(MAXC, err, seen);
            end
        join
        check(seen && !err, "samecyc_fill_ok", {30'd0, seen, err}, 32'd2);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fill_done) dcnt++;
        end
        check(dcnt == 0, "samecyc_no_second_done", 32'(dcnt), 32'd0);
        check(exp_q.size() == 0, "samecyc_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort while pending, before any traffic
        pbase = psel_cnt;
        fill_abort = 1'b1;
        start_fill(16'd0, 16'd3, 16'd0, 16'd3, 16'h1111);
        wait_done(20, err, seen);
        #1 fill_abort = 1'b0;
        check(seen && err, "abort_pending", {30'd0, seen, err}, 32'd3);
        check(psel_cnt == pbase, "abort_pending_no_traffic", 32'(psel_cnt - pbase), 32'd0);

        // Abort after three pixels of a 100-pixel fill
        @(posedge clk);
        base = xfer_cnt;
        push_fill(16'd0, 16'd9, 16'd0, 16'd9, 16'hC0DE, 3);
        start_fill(16'd0, 16'd9, 16'd0, 16'd9, 16'hC0DE);
        hit = 0;
        for (int i = 0; i < MAXC && !hit; i++) begin
            @(posedge clk);
            if (xfer_cnt - base >= 20) hit = 1;
        end
        #1 fill_abort = 1'b1;
        check(hit, "abort_reach_px3", 32'(xfer_cnt - base), 32'd20);
        wait_done(100, err, seen);
        #1 fill_abort = 1'b0;
        check(seen && err, "abort_done_err", {30'd0, seen, err}, 32'd3);
        repeat (5) @(posedge clk);
        check(xfer_cnt - base == 20, "abort_xfer_count", 32'(xfer_cnt - base), 32'd20);
        check(exp_q.size() == 0, "abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of an access phase
        lat = 3;
        base = xfer_cnt;
        push_fill(16'd0, 16'd3, 16'd0, 16'd3, 16'hAAAA, -1);
        start_fill(16'd0, 16'd3, 16'd0, 16'd3, 16'hAAAA);
        hit = 0;
        for (int i = 0; i < MAXC && !hit; i++) begin
            @(negedge clk);
            if (M_penable && (xfer_cnt - base >= 5)) hit = 1;
        end
        check(hit, "rst_reach_access", 32'(xfer_cnt - base), 32'd5);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({M_psel, M_penable, M_pwrite, fill_busy, fill_done, fill_err} == 6'd0, "rst_mid_ctrl",
              {26'd0, M_psel, M_penable, M_pwrite, fill_busy, fill_done, fill_err}, 32'd0);
        check(M_paddr == 32'd0 && M_pwdata == 32'd0, "rst_mid_bus", M_paddr | M_pwdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        lat = 1;

        // Recovery: a fresh 1x1 fill after reset
        push_fill(16'd5, 16'd5, 16'd6, 16'd6, 16'h4321, -1);
        start_fill(16'd5, 16'd5, 16'd6, 16'd6, 16'h4321);
        wait_done(MAXC, err, seen);
        check(seen && !err, "recover_fill_ok", {30'd0, seen, err}, 32'd2);
        repeat (3) @(posedge clk);
        check(exp_q.size() == 0, "final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
